sha256_block_sequencer: RTL

- Controller between the byte-stream front end (UART receive path) and the SHA-256 compression core.
- Absorbs message bytes into a 512-bit block buffer and applies SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length).
- Issues each completed block to the core as 16 consecutive 32-bit words, waits for the core to finish, and signals when the final digest is ready.
- Handles multi-block messages, including the extra padding block.

---
 rtl/sha256_block_sequencer.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_block_sequencer.sv
// SHA-256 block sequencer: absorbs message bytes, pads them, and streams 512-bit blocks to the core.
// Optional feature macro SHA_SEQ_PERF_EN adds the blk_count output (blocks issued since last digest).
module sha256_block_sequencer #(
    parameter int LEN_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        core_ready,
    input  logic        core_done,
    output logic [31:0] blk_word,
    output logic        blk_word_valid,
    output logic [3:0]  blk_word_idx,
    output logic        blk_first,
    output logic        blk_last,
    output logic        digest_go,
    output logic        busy,
    output logic        err_len
`ifdef SHA_SEQ_PERF_EN
    ,
    output logic [15:0] blk_count
`endif
);

    typedef enum logic [2:0] {
        ST_ABSORB     = 3'd0,
        ST_PAD        = 3'd1,
        ST_LEN        = 3'd2,
        ST_ISSUE_WAIT = 3'd3,
        ST_SEND       = 3'd4,
        ST_WAIT_DONE  = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    state_t             state_r, state_nx_s;
    logic [6:0]         ptr_r, ptr_nx_s;
    logic [LEN_W-1:0]   byte_cnt_r, byte_cnt_nx_s;
    logic               first_r, first_nx_s;
    logic               final_r, final_nx_s;
    logic               pad_act_r, pad_act_nx_s;
    logic               pad80_r, pad80_nx_s;
    logic [3:0]         idx_r, idx_nx_s;
    logic               err_len_r, err_len_nx_s;
    logic               wr_byte_en_s;
    logic [7:0]         wr_byte_s;
    logic               len_wr_s;
    logic [4:0]         lane_lsb_s;
    logic [63:0]        bit_len_s;
    logic [31:0]        buf_r [16];

    logic               in_ready_r;
    logic [31:0]        blk_word_r;
    logic               blk_word_valid_r;
    logic [3:0]         blk_word_idx_r;
    logic               blk_first_r;
    logic               blk_last_r;
    logic               digest_go_r;
    logic               busy_r;

    // Byte 0 of a word lands in its most significant lane (big-endian packing).
    assign lane_lsb_s = 5'd24 - {ptr_r[1:0], 3'b000};
    assign bit_len_s  = 64'({byte_cnt_r, 3'b000});

    // Next-state and datapath control.
    always_comb begin
        state_nx_s    = state_r;
        ptr_nx_s      = ptr_r;
        byte_cnt_nx_s = byte_cnt_r;
        first_nx_s    = first_r;
        final_nx_s    = final_r;
        pad_act_nx_s  = pad_act_r;
        pad80_nx_s    = pad80_r;
        idx_nx_s      = idx_r;
        err_len_nx_s  = err_len_r;
        wr_byte_en_s  = 1'b0;
        wr_byte_s     = 8'h00;
        len_wr_s      = 1'b0;
        case (state_r)
            ST_ABSORB: begin
                if (in_valid) begin
                    wr_byte_en_s  = 1'b1;
                    wr_byte_s     = in_byte;
                    ptr_nx_s      = ptr_r + 7'd1;
                    byte_cnt_nx_s = byte_cnt_r + LEN_W'(1);
                    if (byte_cnt_r == {LEN_W{1'b1}}) begin
                        err_len_nx_s = 1'b1;
                    end else begin
                        err_len_nx_s = err_len_r;
                    end
                    if (in_last) begin
                        pad_act_nx_s = 1'b1;
                        pad80_nx_s   = 1'b0;
                        // A last byte filling the block issues it before padding begins.
                        if (ptr_r == 7'd63) begin
                            state_nx_s = ST_ISSUE_WAIT;
                        end else begin
                            state_nx_s = ST_PAD;
                        end
                    end else if (ptr_r == 7'd63) begin
                        state_nx_s = ST_ISSUE_WAIT;
                    end else begin
                        state_nx_s = ST_ABSORB;
                    end
                end else begin
                    state_nx_s = ST_ABSORB;
                end
            end
            ST_PAD: begin
                wr_byte_en_s = 1'b1;
                wr_byte_s    = pad80_r ? 8'h00 : 8'h80;
                pad80_nx_s   = 1'b1;
                ptr_nx_s     = ptr_r + 7'd1;
                if (ptr_r == 7'd55) begin
                    state_nx_s = ST_LEN;
                end else if (ptr_r == 7'd63) begin
                    state_nx_s = ST_ISSUE_WAIT;
                end else begin
                    state_nx_s = ST_PAD;
                end
            end
            ST_LEN: begin
                len_wr_s     = 1'b1;
                final_nx_s   = 1'b1;
                pad_act_nx_s = 1'b0;
                state_nx_s   = ST_ISSUE_WAIT;
            end
            ST_ISSUE_WAIT: begin
                if (core_ready) begin
                    state_nx_s = ST_SEND;
                    idx_nx_s   = 4'd0;
                end else begin
                    state_nx_s = ST_ISSUE_WAIT;
                end
            end
            ST_SEND: begin
                idx_nx_s = idx_r + 4'd1;
                if (idx_r == 4'd15) begin
                    state_nx_s = ST_WAIT_DONE;
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_WAIT_DONE: begin
                if (core_done) begin
                    first_nx_s = 1'b0;
                    ptr_nx_s   = 7'd0;
                    if (final_r) begin
                        state_nx_s = ST_DONE;
                    end else if (pad_act_r) begin
                        state_nx_s = ST_PAD;
                    end else begin
                        state_nx_s = ST_ABSORB;
                    end
                end else begin
                    state_nx_s = ST_WAIT_DONE;
                end
            end
            ST_DONE: begin
                state_nx_s    = ST_ABSORB;
                ptr_nx_s      = 7'd0;
                first_nx_s    = 1'b1;
                final_nx_s    = 1'b0;
                byte_cnt_nx_s = '0;
            end
            default: begin
                state_nx_s = ST_ABSORB;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_ABSORB;
            ptr_r      <= 7'd0;
            byte_cnt_r <= '0;
            first_r    <= 1'b1;
            final_r    <= 1'b0;
            pad_act_r  <= 1'b0;
            pad80_r    <= 1'b0;
            idx_r      <= 4'd0;
            err_len_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ptr_r      <= ptr_nx_s;
            byte_cnt_r <= byte_cnt_nx_s;
            first_r    <= first_nx_s;
            final_r    <= final_nx_s;
            pad_act_r  <= pad_act_nx_s;
            pad80_r    <= pad80_nx_s;
            idx_r      <= idx_nx_s;
            err_len_r  <= err_len_nx_s;
        end
    end

    // Block buffer; contents after reset are irrelevant since every byte is rewritten before issue.
    always_ff @(posedge clk) begin
        if (wr_byte_en_s) begin
            buf_r[ptr_r[5:2]][lane_lsb_s +: 8] <= wr_byte_s;
        end else if (len_wr_s) begin
            buf_r[14] <= bit_len_s[63:32];
            buf_r[15] <= bit_len_s[31:0];
        end
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r       <= 1'b1;
            blk_word_r       <= 32'd0;
            blk_word_valid_r <= 1'b0;
            blk_word_idx_r   <= 4'd0;
            blk_first_r      <= 1'b0;
            blk_last_r       <= 1'b0;
            digest_go_r      <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            in_ready_r       <= (state_nx_s == ST_ABSORB);
            blk_word_valid_r <= (state_nx_s == ST_SEND);
            digest_go_r      <= (state_nx_s == ST_DONE);
            busy_r           <= !((state_nx_s == ST_ABSORB) && (ptr_nx_s == 7'd0) && first_nx_s);
            if (state_nx_s == ST_SEND) begin
                blk_word_r     <= buf_r[idx_nx_s];
                blk_word_idx_r <= idx_nx_s;
                blk_first_r    <= first_nx_s;
                blk_last_r     <= final_nx_s;
            end else begin
                blk_word_r     <= 32'd0;
                blk_word_idx_r <= 4'd0;
                blk_first_r    <= 1'b0;
                blk_last_r     <= 1'b0;
            end
        end
    end

    assign in_ready       = in_ready_r;
    assign blk_word       = blk_word_r;
    assign blk_word_valid = blk_word_valid_r;
    assign blk_word_idx   = blk_word_idx_r;
    assign blk_first      = blk_first_r;
    assign blk_last       = blk_last_r;
    assign digest_go      = digest_go_r;
    assign busy           = busy_r;
    assign err_len        = err_len_r;

`ifdef SHA_SEQ_PERF_EN
    logic [15:0] blk_count_r;

    // Blocks issued since the last digest; counted as each block finishes streaming.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count_r <= 16'd0;
        end else if (state_r == ST_DONE) begin
            blk_count_r <= 16'd0;
        end else if ((state_r == ST_SEND) && (idx_r == 4'd15)) begin
            blk_count_r <= blk_count_r + 16'd1;
        end else begin
            blk_count_r <= blk_count_r;
        end
    end

    assign blk_count = blk_count_r;
`endif

endmodule
